// File: rtl/urv_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between uRV fetch and data ports,
// and diverts data accesses at or above g_io_base to a handshaked MMIO port.
module urv_mem_arbiter #(
  parameter int          g_addr_width   = 14,
  parameter logic [31:0] g_io_base      = 32'h00100000,
  parameter int          g_max_dm_burst = 4,
  parameter int          g_io_timeout   = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             im_addr_i,
  input  logic                    im_rd_i,
  output logic [31:0]             im_data_o,
  output logic                    im_valid_o,
  input  logic [31:0]             dm_addr_i,
  input  logic [31:0]             dm_data_s_i,
  input  logic [3:0]              dm_data_select_i,
  input  logic                    dm_store_i,
  input  logic                    dm_load_i,
  output logic [31:0]             dm_data_l_o,
  output logic                    dm_load_done_o,
  output logic                    dm_store_done_o,
  output logic [g_addr_width-1:0] ram_addr_o,
  output logic [31:0]             ram_data_o,
  output logic [3:0]              ram_bwe_o,
  input  logic [31:0]             ram_data_i,
  output logic [31:0]             io_addr_o,
  output logic [31:0]             io_data_o,
  output logic                    io_we_o,
  output logic                    io_re_o,
  input  logic [31:0]             io_data_i,
  input  logic                    io_ack_i,
  output logic                    bus_err_o
);

  localparam int BW = $clog2(g_max_dm_burst + 1);
  localparam int TW = $clog2(g_io_timeout + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(g_max_dm_burst);
  localparam logic [TW-1:0] TO_LAST   = TW'(g_io_timeout - 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, MEM_DATA, IO_WAIT} state_t;
  typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE} own_t;

  state_t         state;
  own_t           own;
  logic [BW-1:0]  burst_cnt;
  logic [TW-1:0]  to_cnt;
  logic [31:0]    io_rdata;

  logic dm_req, data_win, dm_is_io;
  logic unused_addr_bits;

  assign dm_req   = dm_load_i | dm_store_i;
  assign data_win = dm_req && !(im_rd_i && burst_cnt == BURST_MAX);
  assign dm_is_io = dm_addr_i >= g_io_base;
  assign unused_addr_bits = ^{im_addr_i[31:g_addr_width+2], im_addr_i[1:0], dm_addr_i[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      own             <= OWN_FETCH;
      burst_cnt       <= '0;
      to_cnt          <= '0;
      io_rdata        <= '0;
      im_data_o       <= '0;
      im_valid_o      <= 1'b0;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      ram_addr_o      <= '0;
      ram_data_o      <= '0;
      ram_bwe_o       <= '0;
      io_addr_o       <= '0;
      io_data_o       <= '0;
      io_we_o         <= 1'b0;
      io_re_o         <= 1'b0;
      bus_err_o       <= 1'b0;
    end else begin
      im_valid_o      <= 1'b0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_err_o       <= 1'b0;
      ram_bwe_o       <= '0;

      case (state)
        IDLE: begin
          if (data_win) begin
            burst_cnt <= burst_cnt + 1'b1;
            own       <= dm_store_i ? OWN_STORE : OWN_LOAD;
            if (dm_is_io) begin
              io_addr_o <= dm_addr_i;
              io_data_o <= dm_data_s_i;
              io_we_o   <= dm_store_i;
              io_re_o   <= !dm_store_i;
              to_cnt    <= '0;
              state     <= IO_WAIT;
            end else begin
              ram_addr_o <= dm_addr_i[g_addr_width+1:2];
              if (dm_store_i) begin
                ram_bwe_o  <= dm_data_select_i;
                ram_data_o <= dm_data_s_i;
              end
              state <= MEM_WAIT;
            end
          end else if (im_rd_i) begin
            burst_cnt  <= '0;
            own        <= OWN_FETCH;
            ram_addr_o <= im_addr_i[g_addr_width+1:2];
            state      <= MEM_WAIT;
          end
        end

        MEM_WAIT: begin
          if (own == OWN_STORE) begin
            dm_store_done_o <= 1'b1;
            state           <= IDLE;
          end else begin
            state <= MEM_DATA;
          end
        end

        MEM_DATA: begin
          if (own == OWN_FETCH) begin
            im_data_o  <= ram_data_i;
            im_valid_o <= 1'b1;
          end else begin
            dm_data_l_o    <= ram_data_i;
            dm_load_done_o <= 1'b1;
          end
          state <= IDLE;
        end

        IO_WAIT: begin
          // Strobes still high: waiting for ack. Strobes low: ack was seen last edge.
          if (io_we_o || io_re_o) begin
            if (io_ack_i) begin
              io_we_o  <= 1'b0;
              io_re_o  <= 1'b0;
              io_rdata <= io_data_i;
            end else if (to_cnt == TO_LAST) begin
              io_we_o   <= 1'b0;
              io_re_o   <= 1'b0;
              bus_err_o <= 1'b1;
              if (own == OWN_STORE) begin
                dm_store_done_o <= 1'b1;
              end else begin
                dm_load_done_o <= 1'b1;
                dm_data_l_o    <= 32'hDEADBEEF;
              end
              state <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            if (own == OWN_STORE) begin
              dm_store_done_o <= 1'b1;
            end else begin
              dm_load_done_o <= 1'b1;
              dm_data_l_o    <= io_rdata;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (!im_rd_i) burst_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Scoreboarded bench for urv_mem_arbiter with a behavioural RAM and MMIO responder.
module tb_urv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] im_addr_i, dm_addr_i, dm_data_s_i;
  logic        im_rd_i, dm_store_i, dm_load_i;
  logic [3:0]  dm_data_select_i;
  logic [31:0] im_data_o, dm_data_l_o;
  logic        im_valid_o, dm_load_done_o, dm_store_done_o;
  logic [13:0] ram_addr_o;
  logic [31:0] ram_data_o, ram_data_i;
  logic [3:0]  ram_bwe_o;
  logic [31:0] io_addr_o, io_data_o, io_data_i;
  logic        io_we_o, io_re_o, io_ack_i, bus_err_o;

  urv_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .im_addr_i(im_addr_i), .im_rd_i(im_rd_i), .im_data_o(im_data_o), .im_valid_o(im_valid_o),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_store_i(dm_store_i), .dm_load_i(dm_load_i), .dm_data_l_o(dm_data_l_o),
    .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_bwe_o(ram_bwe_o), .ram_data_i(ram_data_i),
    .io_addr_o(io_addr_o), .io_data_o(io_data_o), .io_we_o(io_we_o), .io_re_o(io_re_o),
    .io_data_i(io_data_i), .io_ack_i(io_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  localparam logic [2:0] K_F = 3'b100, K_L = 3'b010, K_S = 3'b001;
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // RAM model: byte-write, registered read; preload port for test setup
  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk_i) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    for (int b = 0; b < 4; b++)
      if (ram_bwe_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
    ram_data_i <= mem[ram_addr_o];
  end

  // MMIO responder: ack one cycle after the strobe has been high ack_dly cycles; -1 never acks
  int          ack_dly = -1;
  int          str_cyc = 0;
  logic [31:0] io_rd_val = 32'h0;
  always @(negedge clk_i) begin
    io_data_i = io_rd_val;
    if ((io_we_o || io_re_o) && ack_dly >= 0) begin
      io_ack_i = (str_cyc == ack_dly);
      str_cyc++;
    end else begin
      io_ack_i = 1'b0;
      str_cyc  = 0;
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    logic [2:0] got;
    if (!rst_i) begin
      got = {im_valid_o, dm_load_done_o, dm_store_done_o};
      if (got != 3'b000) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: completion %b at cycle %0d with nothing pending", got, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e.kind) begin
            errors++;
            $display("FAIL sb_kind: got %b want %b (cycle %0d)", got, e.kind, cyc);
          end
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL sb_cycle: got %0d want %0d", cyc, e.cyc);
          end
          if (bus_err_o !== e.err) begin
            errors++;
            $display("FAIL sb_bus_err: got %b want %b", bus_err_o, e.err);
          end
          if (e.kind == K_F && im_data_o !== e.data) begin
            errors++;
            $display("FAIL sb_im_data: got %h want %h", im_data_o, e.data);
          end
          if (e.kind == K_L && dm_data_l_o !== e.data) begin
            errors++;
            $display("FAIL sb_dm_data: got %h want %h", dm_data_l_o, e.data);
          end
        end
      end else if (bus_err_o) begin
        errors++;
        $display("FAIL bus_err_alone: got 1 want 0 at cycle %0d", cyc);
      end
      if (io_we_o && io_re_o) begin
        errors++;
        $display("FAIL io_strobes: we=1 re=1 want never both");
      end
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk_i);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d completions outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({im_valid_o, dm_load_done_o, dm_store_done_o, io_we_o, io_re_o, bus_err_o, ram_bwe_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {im_valid_o, dm_load_done_o, dm_store_done_o, io_we_o, io_re_o, bus_err_o, ram_bwe_o});
    end
    vectors++;
    if ({im_data_o, dm_data_l_o, ram_data_o, io_addr_o, io_data_o, ram_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got nonzero want all 0");
    end
    rst_i = 1'b0;
  endtask

  task automatic test_fetch();
    int c, n;
    preload(14'd16, 32'h00000013);
    @(negedge clk_i);
    c = cyc;
    im_addr_i = 32'h40; im_rd_i = 1'b1;
    exp_q.push_back('{K_F, 32'h00000013, 1'b0, c + 3});
    @(negedge clk_i);
    vectors++;
    if (ram_addr_o !== 14'd16 || ram_bwe_o !== 4'b0) begin
      errors++;
      $display("FAIL fetch_addr: got addr %0d bwe %b want 16 0000", ram_addr_o, ram_bwe_o);
    end
    n = 0;
    while (!im_valid_o && n < 10) begin @(negedge clk_i); n++; end
    im_rd_i = 1'b0;
    drain("fetch");
  endtask

  task automatic test_store_load();
    int c, n;
    preload(14'd32, 32'h0);
    @(negedge clk_i);
    c = cyc;
    dm_addr_i = 32'h80; dm_data_s_i = 32'hAABBCCDD; dm_data_select_i = 4'b0101; dm_store_i = 1'b1;
    exp_q.push_back('{K_S, 32'h0, 1'b0, c + 2});
    @(negedge clk_i);
    vectors++;
    if (ram_bwe_o !== 4'b0101 || ram_addr_o !== 14'd32 || ram_data_o !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL store_grant: got bwe %b addr %0d data %h want 0101 32 aabbccdd", ram_bwe_o, ram_addr_o, ram_data_o);
    end
    @(negedge clk_i);
    vectors++;
    if (ram_bwe_o !== 4'b0) begin
      errors++;
      $display("FAIL store_bwe_one_cycle: got %b want 0000", ram_bwe_o);
    end
    dm_store_i = 1'b0;
    @(negedge clk_i);
    c = cyc;
    dm_load_i = 1'b1;
    exp_q.push_back('{K_L, 32'h00BB00DD, 1'b0, c + 3});
    n = 0;
    do begin @(negedge clk_i); n++; end while (!dm_load_done_o && n < 10);
    dm_load_i = 1'b0;
    drain("store_load");
  endtask

  task automatic test_back_to_back();
    int c, n, done_cnt, f_cnt;
    preload(14'd48, 32'h11111111);
    preload(14'd64, 32'h22222222);
    @(negedge clk_i);
    c = cyc;
    im_addr_i = 32'hC0; im_rd_i = 1'b1;
    dm_addr_i = 32'h100; dm_load_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) exp_q.push_back('{K_F, 32'h11111111, 1'b0, c + 3*(i+1)});
      else            exp_q.push_back('{K_L, 32'h22222222, 1'b0, c + 3*(i+1)});
    end
    n = 0; done_cnt = 0; f_cnt = 0;
    while (done_cnt < 10 && n < 60) begin
      @(negedge clk_i);
      n++;
      if (im_valid_o || dm_load_done_o) done_cnt++;
      if (im_valid_o) f_cnt++;
    end
    im_rd_i = 1'b0; dm_load_i = 1'b0;
    vectors++;
    if (f_cnt != 2) begin
      errors++;
      $display("FAIL b2b_fetch_count: got %0d want 2", f_cnt);
    end
    drain("b2b");
  endtask

  task automatic test_io_store();
    int c, n, we_cnt;
    logic ram_wr;
    ack_dly = 2;
    @(negedge clk_i);
    c = cyc;
    dm_addr_i = 32'h00100000; dm_data_s_i = 32'h41; dm_data_select_i = 4'b1111; dm_store_i = 1'b1;
    exp_q.push_back('{K_S, 32'h0, 1'b0, c + 5});
    n = 0; we_cnt = 0; ram_wr = 1'b0;
    do begin
      @(negedge clk_i); n++;
      if (io_we_o) we_cnt++;
      if (ram_bwe_o != 4'b0) ram_wr = 1'b1;
    end while (!dm_store_done_o && n < 30);
    dm_store_i = 1'b0;
    vectors++;
    if (io_addr_o !== 32'h00100000 || io_data_o !== 32'h41) begin
      errors++;
      $display("FAIL io_store_regs: got addr %h data %h want 00100000 00000041", io_addr_o, io_data_o);
    end
    vectors++;
    if (we_cnt != 3 || ram_wr) begin
      errors++;
      $display("FAIL io_store_strobe: got we cycles %0d ram write %b want 3 0", we_cnt, ram_wr);
    end
    repeat (3) @(negedge clk_i);
    drain("io_store");
  endtask

  task automatic test_io_load_ack();
    int c, n;
    ack_dly = 0; io_rd_val = 32'h12345678;
    @(negedge clk_i);
    c = cyc;
    dm_addr_i = 32'h00100004; dm_load_i = 1'b1;
    exp_q.push_back('{K_L, 32'h12345678, 1'b0, c + 3});
    n = 0;
    do begin @(negedge clk_i); n++; end while (!dm_load_done_o && n < 30);
    dm_load_i = 1'b0;
    drain("io_load_ack");
  endtask

  task automatic test_io_timeout();
    int c, n, re_cnt;
    ack_dly = -1;
    @(negedge clk_i);
    c = cyc;
    dm_addr_i = 32'h00100008; dm_load_i = 1'b1;
    exp_q.push_back('{K_L, 32'hDEADBEEF, 1'b1, c + 16});
    n = 0; re_cnt = 0;
    do begin
      @(negedge clk_i); n++;
      if (io_re_o) re_cnt++;
    end while (!dm_load_done_o && n < 40);
    dm_load_i = 1'b0;
    vectors++;
    if (re_cnt != 15 || io_addr_o !== 32'h00100008) begin
      errors++;
      $display("FAIL io_timeout_strobe: got re cycles %0d addr %h want 15 00100008", re_cnt, io_addr_o);
    end
    drain("io_timeout");
  endtask

  task automatic test_reset_abort();
    int c, n;
    preload(14'd40, 32'h5A5A5A5A);
    @(negedge clk_i);
    dm_addr_i = 32'hA0; dm_data_s_i = 32'hFFFFFFFF; dm_data_select_i = 4'b1111; dm_store_i = 1'b1;
    @(posedge clk_i);
    #2;
    vectors++;
    if (ram_bwe_o !== 4'b1111) begin
      errors++;
      $display("FAIL abort_pre: got bwe %b want 1111", ram_bwe_o);
    end
    rst_i = 1'b1; dm_store_i = 1'b0;
    #1;
    vectors++;
    if (ram_bwe_o !== 4'b0) begin
      errors++;
      $display("FAIL abort_async: got bwe %b want 0000", ram_bwe_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    vectors++;
    if (mem[40] !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL abort_no_write: got %h want 5a5a5a5a", mem[40]);
    end
    c = cyc;
    im_addr_i = 32'hA0; im_rd_i = 1'b1;
    exp_q.push_back('{K_F, 32'h5A5A5A5A, 1'b0, c + 3});
    n = 0;
    do begin @(negedge clk_i); n++; end while (!im_valid_o && n < 10);
    im_rd_i = 1'b0;
    drain("abort_fetch");
  endtask

  initial begin
    rst_i = 1'b1;
    im_addr_i = '0; im_rd_i = 1'b0;
    dm_addr_i = '0; dm_data_s_i = '0; dm_data_select_i = '0;
    dm_store_i = 1'b0; dm_load_i = 1'b0;
    io_ack_i = 1'b0; io_data_i = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_io_store();
    test_io_load_ack();
    test_io_timeout();
    test_reset_abort();
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
